wb_arbiter: RTL and testbench

- Single-writer front end for the 32x32 register file write port (we/waddr/wdata).
- Merges two result sources into the one write port:
  - the in-order pipeline writeback (every cycle, highest priority, no backpressure);
  - a long-latency unit (divider / load-miss return), which uses a valid/ready handshake and is buffered in a small FIFO.
- Also gives the decode stage a pending-write scoreboard (busy1/busy2), so decode stalls on operands still queued.

---
 rtl/wb_arbiter_pkg.sv | 30 +++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/wb_arbiter.sv | 110 +++++++++++
 tb/tb_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arbiter_pkg;

   localparam int unsigned WB_FIFO_DEPTH = 4;
   localparam int unsigned REG_ADDR_W    = 5;
   localparam int unsigned REG_W         = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      reg_word_t;

   localparam reg_word_t ZERO_WORD = '0;
   localparam reg_addr_t ZERO_ADDR = '0;

   typedef struct packed {
      logic      valid;
      reg_addr_t waddr;
      reg_word_t wdata;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_PIPE,
      SEL_FIFO
   } wb_sel_e;

   function automatic logic addr_is_dropped(input reg_addr_t a, input bit drop_r0);
      return drop_r0 && (a == ZERO_ADDR);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Long-latency result queue with per-entry valid bits, address-match kill
// and per-entry read-address match vectors for the decode scoreboard.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter  int unsigned DEPTH = WB_FIFO_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             push_valid,
   input  reg_addr_t        push_waddr,
   input  reg_word_t        push_wdata,
   input  logic             pop,
   input  logic             kill,
   input  reg_addr_t        kill_addr,
   input  reg_addr_t        raddr1,
   input  reg_addr_t        raddr2,
   output logic             full,
   output wb_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic [DEPTH-1:0] match1,
   output logic [DEPTH-1:0] match2
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;

   // Popped slots have their valid bit cleared, so only occupied entries can
   // ever be valid and the match logic need not consult the pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i].valid <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (kill && mem[i].valid && (mem[i].waddr == kill_addr))
               mem[i].valid <= 1'b0;
         end
         if (pop) begin
            mem[head_ptr].valid <= 1'b0;
            head_ptr            <= head_ptr + 1'b1;
         end
         if (push) begin
            mem[tail_ptr] <= '{valid: push_valid, waddr: push_waddr, wdata: push_wdata};
            tail_ptr      <= tail_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      match1 = '0;
      match2 = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         match1[i] = mem[i].valid && (mem[i].waddr == raddr1);
         match2[i] = mem[i].valid && (mem[i].waddr == raddr2);
      end
   end

   assign full = (count == CNT_W'(DEPTH));
   assign head = mem[head_ptr];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the
// long-latency unit drains through wb_fifo; also drives decode busy flags.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH   = WB_FIFO_DEPTH,
   parameter bit          DROP_R0 = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_we,
   input  logic [4:0]               pipe_waddr,
   input  logic [31:0]              pipe_wdata,
   input  logic                     lu_valid,
   output logic                     lu_ready,
   input  logic [4:0]               lu_waddr,
   input  logic [31:0]              lu_wdata,
   input  logic [4:0]               raddr1,
   input  logic [4:0]               raddr2,
   output logic                     busy1,
   output logic                     busy2,
   output logic                     we,
   output logic [4:0]               waddr,
   output logic [31:0]              wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     idle
);

   logic             pipe_fire;
   logic             lu_fire;
   logic             push;
   logic             push_valid;
   logic             pop;
   logic             full;
   wb_entry_t        head;
   logic [DEPTH-1:0] match1;
   logic [DEPTH-1:0] match2;
   wb_sel_e          sel;

   assign pipe_fire  = pipe_we && !addr_is_dropped(pipe_waddr, DROP_R0);
   assign lu_ready   = !rst && !full;
   assign lu_fire    = lu_valid && lu_ready;
   assign push       = lu_fire && !addr_is_dropped(lu_waddr, DROP_R0);
   // The pipeline write is program-order younger than a same-cycle push.
   assign push_valid = !(pipe_fire && (lu_waddr == pipe_waddr));
   assign pop        = !rst && (sel == SEL_FIFO);

   always_comb begin
      sel = SEL_NONE;
      if (pipe_fire)          sel = SEL_PIPE;
      else if (count != '0)   sel = SEL_FIFO;
   end

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_valid (push_valid),
      .push_waddr (lu_waddr),
      .push_wdata (lu_wdata),
      .pop        (pop),
      .kill       (pipe_fire),
      .kill_addr  (pipe_waddr),
      .raddr1     (raddr1),
      .raddr2     (raddr2),
      .full       (full),
      .head       (head),
      .count      (count),
      .match1     (match1),
      .match2     (match2)
   );

   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (!rst) begin
         busy1 = (|match1) || (push && push_valid && (lu_waddr == raddr1));
         busy2 = (|match2) || (push && push_valid && (lu_waddr == raddr2));
         if (addr_is_dropped(raddr1, DROP_R0)) busy1 = 1'b0;
         if (addr_is_dropped(raddr2, DROP_R0)) busy2 = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we    <= 1'b0;
         waddr <= ZERO_ADDR;
         wdata <= ZERO_WORD;
      end else begin
         case (sel)
            SEL_PIPE: begin
               we    <= 1'b1;
               waddr <= pipe_waddr;
               wdata <= pipe_wdata;
            end
            SEL_FIFO: begin
               we    <= head.valid;
               waddr <= head.waddr;
               wdata <= head.wdata;
            end
            default: we <= 1'b0;
         endcase
      end
   end

   assign idle = (count == '0) && !we;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, then random
// traffic compared against a queue-based reference model.
module tb_wb_arbiter;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic [4:0]  raddr1;
   logic [4:0]  raddr2;
   logic        busy1;
   logic        busy2;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [2:0]  count;
   logic        idle;

   wb_arbiter #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .lu_valid   (lu_valid),
      .lu_ready   (lu_ready),
      .lu_waddr   (lu_waddr),
      .lu_wdata   (lu_wdata),
      .raddr1     (raddr1),
      .raddr2     (raddr2),
      .busy1      (busy1),
      .busy2      (busy2),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .count      (count),
      .idle       (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        rst;
      logic        pwe;
      logic [4:0]  pa;
      logic [31:0] pd;
      logic        lv;
      logic [4:0]  la;
      logic [31:0] ld;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd;
      logic [2:0]  e_cnt;
      logic        e_rdy;
      logic        e_b1;
      logic        e_b2;
      logic        e_idle;
   } vec_t;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
      bit          v;
   } ent_t;

   vec_t tbl[$];
   ent_t q[$];
   logic        m_we;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int checks   = 0;
   int failures = 0;

   task automatic add(input logic rs, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                      input logic [2:0] ecnt, input logic erdy, input logic eb1, input logic eb2, input logic eidle);
      vec_t v;
      v = '{rst: rs, pwe: pwe, pa: pa, pd: pd, lv: lv, la: la, ld: ld, r1: r1, r2: r2,
            e_we: ewe, e_wa: ewa, e_wd: ewd, e_cnt: ecnt, e_rdy: erdy, e_b1: eb1, e_b2: eb2, e_idle: eidle};
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Reference rules, stated directly on a queue of pending results.
   function automatic bit m_busy(input logic [4:0] ra, input vec_t v);
      bit pf;
      if (v.rst || ra == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].v && q[i].a == ra) return 1'b1;
      pf = v.pwe && v.pa != 5'd0;
      if (v.lv && q.size() < DEPTH && v.la != 5'd0 && !(pf && v.la == v.pa) && v.la == ra)
         return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(input vec_t v);
      bit   pf;
      bit   rdy;
      ent_t h;
      if (v.rst) begin
         q.delete();
         m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      end else begin
         pf  = v.pwe && v.pa != 5'd0;
         rdy = q.size() < DEPTH;
         if (pf) begin
            foreach (q[i]) if (q[i].a == v.pa) q[i].v = 1'b0;
            m_we = 1'b1; m_waddr = v.pa; m_wdata = v.pd;
         end else if (q.size() > 0) begin
            h = q.pop_front();
            m_we = h.v; m_waddr = h.a; m_wdata = h.d;
         end else begin
            m_we = 1'b0;
         end
         if (v.lv && rdy && v.la != 5'd0)
            q.push_back('{a: v.la, d: v.ld, v: !(pf && v.la == v.pa)});
      end
   endtask

   task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
      rst = v.rst; pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
      lu_valid = v.lv; lu_waddr = v.la; lu_wdata = v.ld; raddr1 = v.r1; raddr2 = v.r2;
      @(negedge clk);
      if (use_tbl) begin
         chk({tag, ".we"},    32'(we),       32'(v.e_we));
         chk({tag, ".waddr"}, 32'(waddr),    32'(v.e_wa));
         chk({tag, ".wdata"}, wdata,         v.e_wd);
         chk({tag, ".count"}, 32'(count),    32'(v.e_cnt));
         chk({tag, ".ready"}, 32'(lu_ready), 32'(v.e_rdy));
         chk({tag, ".busy1"}, 32'(busy1),    32'(v.e_b1));
         chk({tag, ".busy2"}, 32'(busy2),    32'(v.e_b2));
         chk({tag, ".idle"},  32'(idle),     32'(v.e_idle));
      end else begin
         chk({tag, ".we"},    32'(we),       32'(m_we));
         if (m_we) begin
            chk({tag, ".waddr"}, 32'(waddr), 32'(m_waddr));
            chk({tag, ".wdata"}, wdata,      m_wdata);
         end
         chk({tag, ".count"}, 32'(count),    q.size());
         chk({tag, ".ready"}, 32'(lu_ready), 32'(!v.rst && q.size() < DEPTH));
         chk({tag, ".busy1"}, 32'(busy1),    32'(m_busy(v.r1, v)));
         chk({tag, ".busy2"}, 32'(busy2),    32'(m_busy(v.r2, v)));
         chk({tag, ".idle"},  32'(idle),     32'(q.size() == 0 && !m_we));
      end
      @(posedge clk);
      model_step(v);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "simulation time limit");
   end

   initial begin
      vec_t v;
      rst = 1'b1; pipe_we = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
      lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0; raddr1 = '0; raddr2 = '0;
      q.delete(); m_we = 1'b0; m_waddr = '0; m_wdata = '0;
      repeat (3) @(posedge clk);
      #1;

      //   rst pwe pa pd        lv la ld            r1 r2  we wa wd            cnt rdy b1 b2 idle
      add(1, 0, 0, 0,          0, 0, 0,            5, 0,  0, 0, 0,            0, 0, 0, 0, 1);
      add(0, 0, 0, 0,          1, 5, 32'h11111111, 5, 0,  0, 0, 0,            0, 1, 1, 0, 1);
      add(0, 0, 0, 0,          0, 0, 0,            5, 0,  0, 0, 0,            1, 1, 1, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            5, 0,  1, 5, 32'h11111111, 0, 1, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            5, 0,  0, 5, 32'h11111111, 0, 1, 0, 0, 1);
      add(0, 1, 3, 32'h30,     1, 7, 32'hA,        7, 3,  0, 5, 32'h11111111, 0, 1, 1, 0, 1);
      add(0, 1, 3, 32'h31,     0, 0, 0,            7, 3,  1, 3, 32'h30,       1, 1, 1, 0, 0);
      add(0, 1, 3, 32'h32,     0, 0, 0,            7, 3,  1, 3, 32'h31,       1, 1, 1, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            7, 3,  1, 3, 32'h32,       1, 1, 1, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            7, 3,  1, 7, 32'hA,        0, 1, 0, 0, 0);
      add(0, 0, 0, 0,          1, 9, 32'hB,        9, 0,  0, 7, 32'hA,        0, 1, 1, 0, 1);
      add(0, 1, 9, 32'hC,      0, 0, 0,            9, 0,  0, 7, 32'hA,        1, 1, 1, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            9, 0,  1, 9, 32'hC,        1, 1, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            9, 0,  0, 9, 32'hB,        0, 1, 0, 0, 1);
      add(0, 1, 20, 32'h100,   1, 1, 32'h1,        1, 4,  0, 9, 32'hB,        0, 1, 1, 0, 1);
      add(0, 1, 20, 32'h100,   1, 2, 32'h2,        1, 4,  1, 20, 32'h100,     1, 1, 1, 0, 0);
      add(0, 1, 20, 32'h100,   1, 3, 32'h3,        1, 4,  1, 20, 32'h100,     2, 1, 1, 0, 0);
      add(0, 1, 20, 32'h100,   1, 4, 32'h4,        1, 4,  1, 20, 32'h100,     3, 1, 1, 1, 0);
      add(0, 1, 20, 32'h100,   1, 5, 32'h5,        1, 4,  1, 20, 32'h100,     4, 0, 1, 1, 0);
      add(0, 0, 0, 0,          1, 5, 32'h5,        1, 4,  1, 20, 32'h100,     4, 0, 1, 1, 0);
      add(0, 0, 0, 0,          1, 5, 32'h5,        1, 4,  1, 1, 32'h1,        3, 1, 0, 1, 0);
      add(0, 0, 0, 0,          0, 0, 0,            1, 4,  1, 2, 32'h2,        3, 1, 0, 1, 0);
      add(0, 0, 0, 0,          0, 0, 0,            1, 4,  1, 3, 32'h3,        2, 1, 0, 1, 0);
      add(0, 0, 0, 0,          0, 0, 0,            1, 4,  1, 4, 32'h4,        1, 1, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            1, 4,  1, 5, 32'h5,        0, 1, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            1, 4,  0, 5, 32'h5,        0, 1, 0, 0, 1);
      add(0, 0, 0, 0,          1, 0, 32'hFF,       0, 0,  0, 5, 32'h5,        0, 1, 0, 0, 1);
      add(0, 0, 0, 0,          0, 0, 0,            0, 0,  0, 5, 32'h5,        0, 1, 0, 0, 1);
      add(0, 1, 6, 32'h66,     1, 0, 32'hFF,       0, 0,  0, 5, 32'h5,        0, 1, 0, 0, 1);
      add(0, 0, 0, 0,          0, 0, 0,            0, 0,  1, 6, 32'h66,       0, 1, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            0, 0,  0, 6, 32'h66,       0, 1, 0, 0, 1);
      add(0, 1, 6, 32'h60,     1, 10, 32'hA0,      10, 11, 0, 6, 32'h66,      0, 1, 1, 0, 1);
      add(0, 1, 6, 32'h61,     1, 11, 32'hA1,      10, 11, 1, 6, 32'h60,      1, 1, 1, 1, 0);
      add(0, 1, 6, 32'h62,     1, 12, 32'hA2,      10, 11, 1, 6, 32'h61,      2, 1, 1, 1, 0);
      add(1, 1, 6, 32'h63,     1, 13, 32'hA3,      10, 11, 1, 6, 32'h62,      3, 0, 0, 0, 0);
      add(0, 0, 0, 0,          0, 0, 0,            10, 11, 0, 0, 0,           0, 1, 0, 0, 1);
      add(0, 0, 0, 0,          0, 0, 0,            10, 11, 0, 0, 0,           0, 1, 0, 0, 1);

      foreach (tbl[i]) run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));

      for (int n = 0; n < 3000; n++) begin
         v.rst  = ($urandom_range(0, 149) == 0);
         v.pwe  = ($urandom_range(0, 1) == 1);
         v.pa   = 5'($urandom_range(0, 7));
         v.pd   = $urandom;
         v.lv   = ($urandom_range(0, 2) != 0);
         v.la   = 5'($urandom_range(0, 7));
         v.ld   = $urandom;
         v.r1   = 5'($urandom_range(0, 7));
         v.r2   = 5'($urandom_range(0, 7));
         v.e_we = 1'b0; v.e_wa = '0; v.e_wd = '0; v.e_cnt = '0;
         v.e_rdy = 1'b0; v.e_b1 = 1'b0; v.e_b2 = 1'b0; v.e_idle = 1'b0;
         run_cycle(v, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
